ex_muldiv: RTL and testbench

Parametrised multi-cycle multiply/divide unit for the execute stage, running beside the single-cycle logic ALU. Executes signed/unsigned iterative multiply (shift-add) and divide (restoring), one bit per cycle. Holds the pipeline through a stall request and returns a double-width HI:LO result through a start/ready handshake. Supports annulment mid-operation, e.g. when the instruction is flushed.

---
 rtl/ex_muldiv_pkg.sv | 31 +++
 rtl/ex_muldiv_if.sv | 35 +++
 rtl/ex_muldiv.sv | 183 ++++++++++++++++++
 tb/tb_ex_muldiv.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg
// Shared execute-stage definitions for the multiply/divide unit. Decode and
// execute both import this package, so the op_i encodings are defined once.
// It also holds the unit's state encoding and two small op-class helpers.
package ex_muldiv_pkg;

    // op_i encodings driven by ID/EX
    localparam logic [1:0] EXE_DIVU_OP  = 2'd0;
    localparam logic [1:0] EXE_DIV_OP   = 2'd1;
    localparam logic [1:0] EXE_MULTU_OP = 2'd2;
    localparam logic [1:0] EXE_MULT_OP  = 2'd3;

    // Unit state encoding (2 bits)
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIVZERO = 2'd1,
        ST_RUN     = 2'd2,
        ST_DONE    = 2'd3
    } muldiv_state_t;

    // True for both divide flavours
    function automatic logic op_is_div(input logic [1:0] op);
        return (op == EXE_DIVU_OP) || (op == EXE_DIV_OP);
    endfunction

    // True for the signed flavours of either operation
    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == EXE_DIV_OP) || (op == EXE_MULT_OP);
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if
// Groups the request/response signals between the ID/EX pipeline register
// (master) and the multi-cycle multiply/divide unit (slave).
//   start_i    : request, held until ready_o is seen
//   op_i       : operation select (see ex_muldiv_pkg)
//   opdata1_i  : dividend / multiplicand
//   opdata2_i  : divisor / multiplier
//   annul_i    : abort the operation in flight
//   result_o   : {HI, LO} result, 2*DATA_W bits
//   ready_o    : result_o valid
//   busy_o     : unit not idle
//   stallreq_o : pipeline stall request
interface ex_muldiv_if #(
    parameter int DATA_W = 32
);
    logic                  start_i;
    logic [1:0]            op_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;
    logic                  busy_o;
    logic                  stallreq_o;

    modport master (
        output start_i, op_i, opdata1_i, opdata2_i, annul_i,
        input  result_o, ready_o, busy_o, stallreq_o
    );

    modport slave (
        input  start_i, op_i, opdata1_i, opdata2_i, annul_i,
        output result_o, ready_o, busy_o, stallreq_o
    );
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv
// Multi-cycle multiply/divide unit for the execute stage. Signed and
// unsigned shift-add multiply and restoring divide run at one bit per
// cycle. The result is returned as {HI, LO} through a start/ready handshake.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : ex_muldiv_if.slave request/response bundle
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    ex_muldiv_if.slave bus
);

    localparam int              CNT_W     = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] DZ_LAST   = CNT_W'(1);

    function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] x, input logic n);
        return n ? -x : x;
    endfunction

    function automatic logic [2*DATA_W-1:0] neg2_if(input logic [2*DATA_W-1:0] x, input logic n);
        return n ? -x : x;
    endfunction

    function automatic logic [DATA_W-1:0] abs_if(input logic [DATA_W-1:0] x, input logic is_signed);
        return neg_if(x, is_signed & x[DATA_W-1]);
    endfunction

    muldiv_state_t        state;
    logic [CNT_W-1:0]     cnt;
    logic                 is_div;
    logic                 neg_a;
    logic                 neg_b;
    logic [DATA_W-1:0]    quot;
    logic [DATA_W-1:0]    rem;
    logic [DATA_W-1:0]    opb;
    logic [2*DATA_W-1:0]  acc;
    logic [2*DATA_W-1:0]  mcand;
    logic [2*DATA_W-1:0]  result_q;
    logic                 ready_q;
    logic                 busy_q;

    logic                 req_div;
    logic                 req_signed;
    logic                 req_divzero;
    logic [DATA_W-1:0]    a_mag;
    logic [DATA_W-1:0]    b_mag;
    logic [DATA_W:0]      rem_shift;
    logic                 fits;
    logic [DATA_W-1:0]    rem_next;
    logic [DATA_W-1:0]    quot_next;
    logic [2*DATA_W-1:0]  acc_next;
    logic [2*DATA_W-1:0]  final_result;

    // Request decode and one iteration of both datapaths. Divide keeps the
    // dividend in quot and shifts its top bit into a DATA_W+1 partial
    // remainder. Each step also shifts one quotient bit into the bottom of
    // quot. The restored remainder is always below the divisor, so it fits
    // back into DATA_W bits. Multiply adds the shifted multiplicand whenever
    // the current low bit of the multiplier is set. On the last step the
    // sign fix-up is applied to the freshly computed values.
    always_comb begin
        req_div     = op_is_div(bus.op_i);
        req_signed  = op_is_signed(bus.op_i);
        req_divzero = req_div && (bus.opdata2_i == '0);
        a_mag       = abs_if(bus.opdata1_i, req_signed);
        b_mag       = abs_if(bus.opdata2_i, req_signed);

        rem_shift = {rem, quot[DATA_W-1]};
        fits      = rem_shift >= {1'b0, opb};
        rem_next  = fits ? (rem_shift[DATA_W-1:0] - opb) : rem_shift[DATA_W-1:0];
        quot_next = {quot[DATA_W-2:0], fits};
        acc_next  = opb[0] ? (acc + mcand) : acc;

        if (is_div) begin
            final_result = {neg_if(rem_next, neg_a), neg_if(quot_next, neg_a ^ neg_b)};
        end else begin
            final_result = neg2_if(acc_next, neg_a ^ neg_b);
        end
    end

    // Control FSM and datapath registers. Annul has priority over everything
    // except reset and drops back to IDLE without ever raising ready. The
    // operands are only looked at in IDLE. Later changes to them are ignored.
    // A zero divisor skips iteration altogether. Its result is known
    // immediately, but DIVZERO is held for two cycles so that ready rises two
    // edges after start is sampled. DONE holds the result until the requester
    // drops start, which keeps a held start from re-triggering the unit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            quot     <= '0;
            rem      <= '0;
            opb      <= '0;
            acc      <= '0;
            mcand    <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else if (bus.annul_i) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        is_div <= req_div;
                        neg_a  <= req_signed & bus.opdata1_i[DATA_W-1];
                        neg_b  <= req_signed & bus.opdata2_i[DATA_W-1];
                        cnt    <= '0;
                        rem    <= '0;
                        acc    <= '0;
                        opb    <= b_mag;
                        mcand  <= {{DATA_W{1'b0}}, a_mag};
                        busy_q <= 1'b1;
                        if (req_divzero) begin
                            state <= ST_DIVZERO;
                            quot  <= bus.opdata1_i;
                        end else begin
                            state <= ST_RUN;
                            quot  <= a_mag;
                        end
                    end
                end
                ST_RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (is_div) begin
                        rem  <= rem_next;
                        quot <= quot_next;
                    end else begin
                        acc   <= acc_next;
                        mcand <= mcand << 1;
                        opb   <= opb >> 1;
                    end
                    if (cnt == LAST_STEP) begin
                        state    <= ST_DONE;
                        result_q <= final_result;
                        ready_q  <= 1'b1;
                    end
                end
                ST_DIVZERO: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == DZ_LAST) begin
                        state    <= ST_DONE;
                        result_q <= {quot, {DATA_W{1'b1}}};
                        ready_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!bus.start_i) begin
                        state   <= ST_IDLE;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The stall request must cover the request cycle itself, before the
    // FSM has left IDLE, so this term is combinational. It is forced low
    // while rst is high.
    assign bus.stallreq_o = !rst &&
                            (((state == ST_IDLE) && bus.start_i && !bus.annul_i) ||
                             (state == ST_RUN) || (state == ST_DIVZERO));
    assign bus.result_o   = result_q;
    assign bus.ready_o    = ready_q;
    assign bus.busy_o     = busy_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv
// Directed bench for ex_muldiv. Two instances are used: a 32-bit one and an
// 8-bit one. Expected results go into per-instance queues when a request is
// issued. A monitor pops and compares them on each rising ready.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rst8;
    logic use8;

    int total = 0;
    int bad   = 0;

    logic [63:0] exp32_q[$];
    logic [63:0] exp8_q[$];

    always #5 clk = ~clk;

    ex_muldiv_if #(.DATA_W(32)) bus32();
    ex_muldiv_if #(.DATA_W(8))  bus8();

    ex_muldiv #(.DATA_W(32)) dut32 (.clk(clk), .rst(rst),  .bus(bus32.slave));
    ex_muldiv #(.DATA_W(8))  dut8  (.clk(clk), .rst(rst8), .bus(bus8.slave));

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic cur_ready();
        return use8 ? bus8.ready_o : bus32.ready_o;
    endfunction

    function automatic logic cur_stall();
        return use8 ? bus8.stallreq_o : bus32.stallreq_o;
    endfunction

    function automatic logic cur_busy();
        return use8 ? bus8.busy_o : bus32.busy_o;
    endfunction

    function automatic logic [63:0] cur_result();
        return use8 ? {48'b0, bus8.result_o} : bus32.result_o;
    endfunction

    task automatic drive(input logic start, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic annul);
        if (use8) begin
            bus8.start_i   = start;
            bus8.op_i      = op;
            bus8.opdata1_i = a[7:0];
            bus8.opdata2_i = b[7:0];
            bus8.annul_i   = annul;
        end else begin
            bus32.start_i   = start;
            bus32.op_i      = op;
            bus32.opdata1_i = a;
            bus32.opdata2_i = b;
            bus32.annul_i   = annul;
        end
    endtask

    // Issue one request and hold start until ready. The operands are then
    // scrambled after the sampling edge. Latency, stall length and the
    // DONE/release handshake are checked. The result itself is checked by
    // the monitor.
    task automatic applyStimulus(input string name, input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [63:0] expected, input int exp_lat);
        int lat;
        int stall;
        if (use8) exp8_q.push_back(expected);
        else      exp32_q.push_back(expected);
        @(posedge clk); #1;
        drive(1'b1, op, a, b, 1'b0);
        @(negedge clk);
        stall = cur_stall() ? 1 : 0;
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (i == 0) drive(1'b1, op ^ 2'd1, ~a, ~b, 1'b0);
            @(negedge clk);
            if (cur_ready()) begin
                lat = i;
                break;
            end
            if (cur_stall()) stall++;
        end
        if (lat < 0) begin
            total++;
            bad++;
            $display("[TB] FAIL %s timeout: got no ready, expected ready after %0d edges", name, exp_lat);
            if (use8) void'(exp8_q.pop_back());
            else      void'(exp32_q.pop_back());
        end else begin
            checkOutput({name, " latency"}, 64'(lat), 64'(exp_lat));
            checkOutput({name, " stall cycles"}, 64'(stall), 64'(exp_lat + 1));
            checkOutput({name, " stallreq in DONE"}, 64'(cur_stall()), 64'd0);
            @(posedge clk); #1;
            @(negedge clk);
            checkOutput({name, " ready held"}, 64'(cur_ready()), 64'd1);
        end
        @(posedge clk); #1;
        drive(1'b0, op, a, b, 1'b0);
        @(posedge clk);
        @(negedge clk);
        checkOutput({name, " ready released"}, 64'(cur_ready()), 64'd0);
        checkOutput({name, " busy released"}, 64'(cur_busy()), 64'd0);
    endtask

    // Scoreboard monitor: each rising ready on either instance consumes one
    // expected result.
    logic r32_q = 1'b0;
    logic r8_q  = 1'b0;
    always @(negedge clk) begin
        if (bus32.ready_o === 1'b1 && !r32_q) begin
            if (exp32_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected ready32: got result %h, expected no ready", bus32.result_o);
            end else begin
                checkOutput("result32", bus32.result_o, exp32_q.pop_front());
            end
        end
        if (bus8.ready_o === 1'b1 && !r8_q) begin
            if (exp8_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected ready8: got result %h, expected no ready", bus8.result_o);
            end else begin
                checkOutput("result8", {48'b0, bus8.result_o}, exp8_q.pop_front());
            end
        end
        r32_q = (bus32.ready_o === 1'b1);
        r8_q  = (bus8.ready_o === 1'b1);
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic seen;
        rst  = 1'b1;
        rst8 = 1'b1;
        use8 = 1'b0;
        drive(1'b1, EXE_DIVU_OP, 32'd1, 32'd1, 1'b0);
        use8 = 1'b1;
        drive(1'b1, EXE_DIVU_OP, 32'd1, 32'd1, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            use8 = (k == 1);
            checkOutput("reset result", cur_result(), 64'd0);
            checkOutput("reset ready", 64'(cur_ready()), 64'd0);
            checkOutput("reset busy", 64'(cur_busy()), 64'd0);
            checkOutput("reset stallreq gated", 64'(cur_stall()), 64'd0);
        end
        drive(1'b0, EXE_DIVU_OP, 32'd0, 32'd0, 1'b0);
        use8 = 1'b0;
        drive(1'b0, EXE_DIVU_OP, 32'd0, 32'd0, 1'b0);
        @(posedge clk); #1;
        rst  = 1'b0;
        rst8 = 1'b0;

        applyStimulus("divu 100/7", EXE_DIVU_OP, 32'd100, 32'd7, {32'd2, 32'd14}, 32);
        applyStimulus("div -7/2", EXE_DIV_OP, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 32);
        applyStimulus("div minneg/-1", EXE_DIV_OP, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 32);
        applyStimulus("mult -3*5", EXE_MULT_OP, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, 32);
        applyStimulus("multu max*max", EXE_MULTU_OP, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 32);
        applyStimulus("divu 5/0", EXE_DIVU_OP, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF}, 2);
        applyStimulus("div -7/0", EXE_DIV_OP, 32'hFFFFFFF9, 32'd0, {32'hFFFFFFF9, 32'hFFFFFFFF}, 2);

        // Annul while cnt == 10
        @(posedge clk); #1;
        drive(1'b1, EXE_DIVU_OP, 32'd1000, 32'd3, 1'b0);
        repeat (11) @(posedge clk);
        #1;
        checkOutput("busy before annul", 64'(cur_busy()), 64'd1);
        drive(1'b1, EXE_DIVU_OP, 32'd1000, 32'd3, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, EXE_DIVU_OP, 32'd1000, 32'd3, 1'b0);
        @(negedge clk);
        checkOutput("annul busy", 64'(cur_busy()), 64'd0);
        checkOutput("annul stallreq", 64'(cur_stall()), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (cur_ready()) seen = 1'b1;
        end
        checkOutput("annul no ready", 64'(seen), 64'd0);
        applyStimulus("divu 9/3", EXE_DIVU_OP, 32'd9, 32'd3, {32'd0, 32'd3}, 32);

        use8 = 1'b1;
        applyStimulus("w8 divu ff/10", EXE_DIVU_OP, 32'hFF, 32'h10, 64'h0F0F, 8);
        applyStimulus("w8 mult -3*5", EXE_MULT_OP, 32'hFD, 32'h05, 64'hFFF1, 8);

        // Reset in the middle of an 8-bit divide
        @(posedge clk); #1;
        drive(1'b1, EXE_DIVU_OP, 32'hFF, 32'h10, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst8 = 1'b1;
        drive(1'b0, EXE_DIVU_OP, 32'hFF, 32'h10, 1'b0);
        @(posedge clk); #1;
        rst8 = 1'b0;
        @(negedge clk);
        checkOutput("w8 rst result", cur_result(), 64'd0);
        checkOutput("w8 rst ready", 64'(cur_ready()), 64'd0);
        checkOutput("w8 rst busy", 64'(cur_busy()), 64'd0);
        checkOutput("w8 rst stallreq", 64'(cur_stall()), 64'd0);
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (cur_ready()) seen = 1'b1;
        end
        checkOutput("w8 rst no ready", 64'(seen), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
